// File: rtl/lfsr_n_checker_if.sv
// Bus between a PRBS word source and lfsr_n_checker.
//   master: drives ena, data_in, clr_err; observes checker status
//   slave : the checker side
//   ena       word valid strobe
//   data_in   received n-bit LFSR word
//   clr_err   synchronous clear of err_count
//   locked    sequence locked
//   err_pulse one-cycle pulse per mismatching word while locked
//   err_count saturating mismatch count
//   state     debug: 0=SEARCH 1=VERIFY 2=LOCKED
//   period / period_valid exist only when LFSR_CHK_PERIOD_EN is defined
interface lfsr_n_checker_if #(
  parameter int n     = 4,
  parameter int ERR_W = 16
);
  logic             ena;
  logic [n-1:0]     data_in;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       state;
`ifdef LFSR_CHK_PERIOD_EN
  logic [n:0]       period;
  logic             period_valid;

  modport master (output ena, data_in, clr_err,
                  input  locked, err_pulse, err_count, state, period, period_valid);
  modport slave  (input  ena, data_in, clr_err,
                  output locked, err_pulse, err_count, state, period, period_valid);
`else
  modport master (output ena, data_in, clr_err,
                  input  locked, err_pulse, err_count, state);
  modport slave  (input  ena, data_in, clr_err,
                  output locked, err_pulse, err_count, state);
`endif
endinterface

// File: rtl/lfsr_n_checker.sv
// Receive-side LFSR checker: acquires lock on an n-bit Fibonacci LFSR word
// stream, then free-runs its own prediction and counts mismatching words.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  lfsr_n_checker_if.slave (ena, data_in, clr_err in;
//        locked, err_pulse, err_count, state [, period, period_valid] out)
// Optional feature macro: LFSR_CHK_PERIOD_EN adds a measured sequence period.
module lfsr_n_checker #(
  parameter int           n          = 4,
  parameter logic [n-1:0] TAPS       = 4'b1100,
  parameter int           LOCK_CNT   = 3,
  parameter int           UNLOCK_CNT = 3,
  parameter int           ERR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  lfsr_n_checker_if.slave   bus
);

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} st_t;

  st_t              st;
  logic [n-1:0]     pred;
  logic [3:0]       match_cnt, miss_cnt;
  logic             locked_q, pulse_q;
  logic [ERR_W-1:0] err_q;

  function automatic logic [n-1:0] nxt(input logic [n-1:0] r);
    return {r[n-2:0], ^(r & TAPS)};
  endfunction

  logic [n-1:0] data_step, pred_step;
  logic         hit, err_hit, lock_now, unlock_now;

  assign data_step  = nxt(bus.data_in);
  assign pred_step  = nxt(pred);
  assign hit        = (bus.data_in == pred);
  assign err_hit    = bus.ena && (st == LOCKED) && !hit;
  assign lock_now   = hit && ((32'(match_cnt) + 1) == LOCK_CNT);
  assign unlock_now = err_hit && ((32'(miss_cnt) + 1) == UNLOCK_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= SEARCH;
      pred      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked_q  <= 1'b0;
      pulse_q   <= 1'b0;
      err_q     <= '0;
    end else begin
      pulse_q <= 1'b0;
      // ena=0 freezes everything, including the error counter and its clear.
      if (bus.ena) begin
        if (bus.clr_err)
          err_q <= err_hit ? ERR_W'(1) : '0;
        else if (err_hit && (err_q != '1))
          err_q <= err_q + 1'b1;

        case (st)
          SEARCH: begin
            // All-zero is the LFSR lock-up word; it can never seed.
            if (bus.data_in != '0) begin
              pred      <= data_step;
              match_cnt <= '0;
              st        <= VERIFY;
            end
          end
          VERIFY: begin
            if (hit) begin
              pred      <= data_step;
              match_cnt <= match_cnt + 4'd1;
              if (lock_now) begin
                st       <= LOCKED;
                locked_q <= 1'b1;
                miss_cnt <= '0;
              end
            end else if (bus.data_in != '0) begin
              pred      <= data_step;
              match_cnt <= '0;
            end else begin
              st <= SEARCH;
            end
          end
          LOCKED: begin
            // Prediction free-runs so a corrupted word cannot derail it.
            pred <= pred_step;
            if (hit) begin
              miss_cnt <= '0;
            end else begin
              pulse_q  <= 1'b1;
              miss_cnt <= miss_cnt + 4'd1;
              if (unlock_now) begin
                st       <= SEARCH;
                locked_q <= 1'b0;
              end
            end
          end
          default: st <= SEARCH;
        endcase
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = pulse_q;
  assign bus.err_count = err_q;
  assign bus.state     = st;

`ifdef LFSR_CHK_PERIOD_EN
  logic [n-1:0] ref_q;
  logic [n:0]   pcnt, period_q;
  logic         pvalid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q    <= '0;
      pcnt     <= '0;
      period_q <= '0;
      pvalid_q <= 1'b0;
    end else if (bus.ena) begin
      if (st == VERIFY && lock_now) begin
        // Reference is the prediction that becomes current on lock.
        ref_q <= data_step;
        pcnt  <= '0;
      end else if (st == LOCKED) begin
        if (unlock_now) begin
          pvalid_q <= 1'b0;
          pcnt     <= '0;
        end else if (pred_step == ref_q) begin
          period_q <= pcnt + 1'b1;
          pvalid_q <= 1'b1;
          pcnt     <= '0;
        end else begin
          pcnt <= pcnt + 1'b1;
        end
      end
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = pvalid_q;
`endif

endmodule

// File: tb/tb_lfsr_n_checker.sv
// Self-checking bench for lfsr_n_checker (n=4, TAPS=x^4+x^3+1, ERR_W=3 so
// saturation is reachable). A spec-level model predicts every output word;
// expectations are queued when a word is driven and compared after the edge.
module tb_lfsr_n_checker;
  localparam int N = 4, EW = 3, CMAX = 7, LOCK = 3, UNLOCK = 3;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  lfsr_n_checker_if #(.n(N), .ERR_W(EW)) bus ();

  lfsr_n_checker #(.n(N), .TAPS(4'b1100), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK),
                   .ERR_W(EW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic locked; logic pulse; int cnt; int st; int period; logic pv;
  } exp_t;
  exp_t q[$];

  int npass = 0, ntot = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // x^4+x^3+1 written out explicitly: feedback = r[3]^r[2]
  function automatic logic [3:0] nx(input logic [3:0] r);
    return {r[2:0], r[3] ^ r[2]};
  endfunction

  // reference model state
  int m_st, m_mc, m_ms, m_cnt, m_pc, m_period;
  logic m_locked, m_pulse, m_pv;
  logic [3:0] m_pred, m_ref;

  task automatic model_reset();
    m_st = 0; m_mc = 0; m_ms = 0; m_cnt = 0; m_pc = 0; m_period = 0;
    m_locked = 0; m_pulse = 0; m_pv = 0; m_pred = 0; m_ref = 0;
  endtask

  task automatic model(input logic e, input logic [3:0] d, input logic c);
    logic miss;
    m_pulse = 0;
    if (!e) return;
    miss = (m_st == 2) && (d != m_pred);
    if (c) m_cnt = miss ? 1 : 0;
    else if (miss) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
    if (miss) m_pulse = 1;
    case (m_st)
      0: if (d != 0) begin m_pred = nx(d); m_mc = 0; m_st = 1; end
      1: begin
        if (d == m_pred) begin
          m_pred = nx(d); m_mc++;
          if (m_mc == LOCK) begin
            m_st = 2; m_locked = 1; m_ms = 0; m_ref = m_pred; m_pc = 0;
          end
        end else if (d != 0) begin
          m_pred = nx(d); m_mc = 0;
        end else m_st = 0;
      end
      default: begin
        m_pred = nx(m_pred);
        if (miss) m_ms++; else m_ms = 0;
        if (m_ms == UNLOCK) begin
          m_st = 0; m_locked = 0; m_pv = 0; m_pc = 0;
        end else begin
          m_pc++;
          if (m_pred == m_ref) begin m_period = m_pc; m_pv = 1; m_pc = 0; end
        end
      end
    endcase
  endtask

  task automatic drive(input logic e, input logic [3:0] d, input logic c);
    exp_t x;
    @(negedge clk);
    bus.ena = e; bus.data_in = d; bus.clr_err = c;
    model(e, d, c);
    x.locked = m_locked; x.pulse = m_pulse; x.cnt = m_cnt; x.st = m_st;
    x.period = m_period; x.pv = m_pv;
    q.push_back(x);
    @(posedge clk); #1;
    if (q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      x = q.pop_front();
      chk("locked", 32'(bus.locked), 32'(x.locked));
      chk("err_pulse", 32'(bus.err_pulse), 32'(x.pulse));
      chk("err_count", 32'(bus.err_count), x.cnt);
      chk("state", 32'(bus.state), x.st);
`ifdef LFSR_CHK_PERIOD_EN
      chk("period", 32'(bus.period), x.period);
      chk("period_valid", 32'(bus.period_valid), 32'(x.pv));
`endif
    end
  endtask

  task automatic async_rst();
    @(negedge clk); #2;
    rst = 1'b1; #1;
    model_reset();
    chk("arst_state", 32'(bus.state), 32'd0);
    chk("arst_locked", 32'(bus.locked), 32'd0);
    chk("arst_err", 32'(bus.err_count), 32'd0);
    @(negedge clk); rst = 1'b0;
  endtask

  logic [3:0] x;

  initial begin
    bus.ena = 0; bus.data_in = 0; bus.clr_err = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_pulse", 32'(bus.err_pulse), 32'd0);
    chk("rst_err", 32'(bus.err_count), 32'd0);
    @(negedge clk); rst = 1'b0;

    // acquisition: 0001,0010,0100,1001,0011
    x = 4'b0001;
    drive(1, x, 0); x = nx(x);
    chk("t1_verify", 32'(bus.state), 32'd1);
    repeat (2) begin drive(1, x, 0); x = nx(x); end
    chk("t1_not_yet", 32'(bus.locked), 32'd0);
    drive(1, x, 0); x = nx(x);            // 1001
    chk("t1_locked", 32'(bus.locked), 32'd1);
    drive(1, x, 0); x = nx(x);            // 0011
    chk("t1_err0", 32'(bus.err_count), 32'd0);

    // single corrupted word 0111 in place of 0110
    chk("t2_seq", 32'(x), 32'b0110);
    drive(1, 4'b0111, 0); x = nx(x);
    chk("t2_pulse", 32'(bus.err_pulse), 32'd1);
    repeat (4) begin drive(1, x, 0); x = nx(x); end
    chk("t2_err1", 32'(bus.err_count), 32'd1);
    chk("t2_locked", 32'(bus.locked), 32'd1);

    // three zero words drop lock, then relock after 4 good words
    repeat (3) begin drive(1, 4'b0000, 0); x = nx(x); end
    chk("t3_unlock", 32'(bus.locked), 32'd0);
    chk("t3_search", 32'(bus.state), 32'd0);
    chk("t3_err4", 32'(bus.err_count), 32'd4);
    repeat (4) begin drive(1, x, 0); x = nx(x); end
    chk("t3_relock", 32'(bus.locked), 32'd1);
    chk("t3_err_kept", 32'(bus.err_count), 32'd4);

    // ena toggling with junk data on idle cycles
    repeat (6) begin
      drive(1, x, 0); x = nx(x);
      drive(0, 4'($urandom), 0);
    end
    async_rst();
    drive(1, x, 0); x = nx(x);
    drive(0, 4'($urandom), 0);
    drive(1, x, 0); x = nx(x);
    drive(0, 4'($urandom), 0);
    chk("t4_verify_hold", 32'(bus.state), 32'd1);
    async_rst();

    // relock, then 10 isolated errors saturate the counter at 7
    repeat (4) begin drive(1, x, 0); x = nx(x); end
    repeat (10) begin
      drive(1, x ^ 4'b0001, 0); x = nx(x);
      drive(1, x, 0); x = nx(x);
    end
    chk("t5_sat", 32'(bus.err_count), 32'd7);
    chk("t5_locked", 32'(bus.locked), 32'd1);
    drive(1, x ^ 4'b0001, 1); x = nx(x);
    chk("t5_clr_err", 32'(bus.err_count), 32'd1);
    drive(1, x, 1); x = nx(x);
    chk("t5_clr", 32'(bus.err_count), 32'd0);

    // continuous sequence for period measurement
    repeat (20) begin drive(1, x, 0); x = nx(x); end
`ifdef LFSR_CHK_PERIOD_EN
    chk("t6_period", 32'(bus.period), 32'd15);
    chk("t6_pvalid", 32'(bus.period_valid), 32'd1);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/lfsr_n_checker.md
Name: lfsr_n_checker

Overview:
- Receive-side counterpart to the LFSR_n generator: accepts the n-bit `random` word stream and predicts each next word.
- Acquires lock on the sequence, then counts mismatching words.
- Used in side-channel and FPGA test setups to confirm that the PRBS source reached the far end intact.
- Sits directly after the generator, or after any transport path that carries its output.

Parameters:
n, 4, LFSR word width (n >= 3)
TAPS, 4'b1100, feedback tap mask (n bits); default is x^4+x^3+1
LOCK_CNT, 3, consecutive matches after the seed needed to declare lock (1..15)
UNLOCK_CNT, 3, consecutive mismatches while locked needed to drop lock (1..15)
ERR_W, 16, width of the error counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
ena  in  1  data_in is a valid word this cycle; when low, all state holds
data_in  in  n  received LFSR word
clr_err  in  1  synchronous clear of err_count
locked  out  1  sequence locked
err_pulse  out  1  one-cycle pulse for each mismatching word while locked
err_count  out  ERR_W  saturating mismatch count
state  out  2  debug: 0=SEARCH, 1=VERIFY, 2=LOCKED

Behaviour:
- LFSR step function: next(r) = {r[n-2:0], ^(r & TAPS)} (Fibonacci, shift left, feedback enters at LSB). This is identical to the generator.
- All outputs are registered and update on the clk edge that samples a word with ena=1. There is no other latency.
- rst (async): state=SEARCH; pred=0; match_cnt=0; miss_cnt=0; locked=0; err_pulse=0; err_count=0.
- ena=0: pred, counters, state and err_count all hold. err_pulse=0.
- err_pulse defaults to 0 on every cycle that does not set it.
- SEARCH:
  - data_in == 0: ignored, because all-zero is the LFSR lock-up state.
  - Otherwise: pred <= next(data_in), match_cnt <= 0, go to VERIFY.
- VERIFY:
  - data_in == pred: pred <= next(data_in), match_cnt++.
  - When match_cnt+1 == LOCK_CNT: go to LOCKED, locked <= 1, miss_cnt <= 0.
  - Mismatch with nonzero data_in: reseed (pred <= next(data_in), match_cnt <= 0), stay in VERIFY.
  - Mismatch with zero data_in: go to SEARCH.
  - No errors are counted in VERIFY.
- LOCKED:
  - pred <= next(pred) on every valid word. The prediction free-runs and is never reloaded from data_in.
  - Match: miss_cnt <= 0.
  - Mismatch: err_pulse <= 1, err_count++ (saturates at all-ones), miss_cnt++.
  - When miss_cnt+1 == UNLOCK_CNT: go to SEARCH, locked <= 0. This last mismatch is still counted and still pulses.
- clr_err: err_count <= 0. If an error occurs in the same cycle, err_count <= 1.
- err_count survives loss and reacquisition of lock. Only rst or clr_err clears it.
- Lock timing: locked rises on the edge that samples the (LOCK_CNT+1)th consecutive correct word, counting the seed.

Optional Feature:
- Macro: LFSR_CHK_PERIOD_EN.
- With the macro defined:
  - Adds outputs period (n+1 bits) and period_valid (1 bit).
  - On entering LOCKED, the checker stores the current pred as ref and clears a word counter.
  - While locked, the counter increments on each valid word.
  - When pred returns to ref, period <= counter value and period_valid <= 1 (sticky until lock is lost), and the counter restarts.
  - Expected period for a maximal-length TAPS is 2^n-1 (15 for the defaults).
- Without the macro: the ports and the logic are absent.

Test Plan:
- Reset then ena=1 with words 0001,0010,0100,1001,0011 -> state goes 0->1 after 0001; locked=1 on the edge sampling 1001; err_count=0.
- Locked; replace expected 0110 with 0111 once, then continue the correct sequence (1101,1010...) -> exactly one err_pulse; err_count=1; locked stays 1.
- Locked; send 3 consecutive wrong words (0000,0000,0000) -> err_count +3; locked=0 on the third; state=0. Resume the correct sequence -> relock after 4 words; err_count is not cleared.
- Stream valid words with ena toggling every other cycle, plus rst asserted mid-VERIFY -> state/pred hold on ena=0; rst forces SEARCH and locked=0 asynchronously.
- Force err_count to all-ones (or use ERR_W=2 with 5 errors) -> saturates at 3. Assert clr_err together with a mismatch -> err_count=1.
- With LFSR_CHK_PERIOD_EN defined, feed the continuous default sequence -> period_valid=1 and period=15, 15 valid words after lock.
